// File: rtl/router_local_input_buffer.sv
// Local-port router input buffer: flit FIFO plus a framing FSM that requests a route and forwards whole packets.
// Define ROUTER_INBUF_STATS_EN to add the pkt_count_o / drop_count_o statistics outputs.
module router_local_input_buffer #(
    parameter int FLIT_WIDTH   = 32,
    parameter int BUFFER_DEPTH = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          rx,
    input  logic [FLIT_WIDTH-1:0]         data_i,
    output logic                          credit_o,
    output logic                          req_o,
    output logic [FLIT_WIDTH-1:0]         dest_o,
    input  logic                          grant_i,
    output logic                          tx,
    output logic [FLIT_WIDTH-1:0]         data_o,
    input  logic                          credit_i,
    output logic                          busy_o,
    output logic [$clog2(BUFFER_DEPTH):0] occupancy_o
`ifdef ROUTER_INBUF_STATS_EN
    ,
    output logic [31:0]                   pkt_count_o,
    output logic [31:0]                   drop_count_o
`endif
);

    localparam int PTR_W = $clog2(BUFFER_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQUEST,
        S_FWD_HEADER,
        S_FWD_SIZE,
        S_FWD_PAYLOAD
    } state_t;

    logic [FLIT_WIDTH-1:0] mem_q [BUFFER_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [FLIT_WIDTH-1:0] remaining_q, remaining_d;
    state_t                state_q, state_d;
    logic                  wr_en;
    logic                  rd_en;
    logic                  last_xfer;
    logic [FLIT_WIDTH-1:0] head;

    // Full blocks writes even when a read frees a slot in the same cycle.
    assign credit_o    = (count_q != CNT_W'(BUFFER_DEPTH));
    assign wr_en       = rx & credit_o;
    assign head        = mem_q[rd_ptr_q];
    assign data_o      = head;
    assign dest_o      = head;
    assign occupancy_o = count_q;
    assign busy_o      = (state_q == S_FWD_HEADER) || (state_q == S_FWD_SIZE)
                         || (state_q == S_FWD_PAYLOAD);
    assign tx          = busy_o & (count_q != '0);
    assign rd_en       = tx & credit_i;

    always_ff @(posedge clock) begin
        if (!reset && wr_en) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_comb begin
        wr_ptr_d = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = rd_en ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        req_o       = 1'b0;
        last_xfer   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (count_q != '0) state_d = S_REQUEST;
            end
            S_REQUEST: begin
                req_o = 1'b1;
                if (grant_i) state_d = S_FWD_HEADER;
            end
            S_FWD_HEADER: begin
                if (rd_en) state_d = S_FWD_SIZE;
            end
            S_FWD_SIZE: begin
                if (rd_en) begin
                    remaining_d = data_o;
                    if (data_o == '0) begin
                        state_d   = S_IDLE;
                        last_xfer = 1'b1;
                    end else begin
                        state_d = S_FWD_PAYLOAD;
                    end
                end
            end
            S_FWD_PAYLOAD: begin
                if (rd_en) begin
                    remaining_d = remaining_q - FLIT_WIDTH'(1);
                    if (remaining_q == FLIT_WIDTH'(1)) begin
                        state_d   = S_IDLE;
                        last_xfer = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            remaining_q <= '0;
            state_q     <= S_IDLE;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            remaining_q <= remaining_d;
            state_q     <= state_d;
        end
    end

`ifdef ROUTER_INBUF_STATS_EN
    logic [31:0] pkt_count_q;
    logic [31:0] drop_count_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            pkt_count_q  <= '0;
            drop_count_q <= '0;
        end else begin
            if (last_xfer) pkt_count_q <= pkt_count_q + 32'd1;
            if (rx && !credit_o) drop_count_q <= drop_count_q + 32'd1;
        end
    end

    assign pkt_count_o  = pkt_count_q;
    assign drop_count_o = drop_count_q;
`else
    logic unused_last_xfer;
    assign unused_last_xfer = last_xfer;
`endif

endmodule

// File: tb/tb_router_local_input_buffer.sv
// Randomised scoreboard bench for router_local_input_buffer: a packet-level model predicts FIFO
// contents, request/forward phases and outputs; a negedge monitor compares every cycle.
module tb_router_local_input_buffer;
    localparam int FW    = 32;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          rx = 1'b0;
    logic [FW-1:0] data_i = '0;
    logic          credit_o;
    logic          req_o;
    logic [FW-1:0] dest_o;
    logic          grant_i = 1'b0;
    logic          tx;
    logic [FW-1:0] data_o;
    logic          credit_i = 1'b1;
    logic          busy_o;
    logic [4:0]    occupancy_o;
`ifdef ROUTER_INBUF_STATS_EN
    logic [31:0]   pkt_count_o;
    logic [31:0]   drop_count_o;
`endif

    always #5 clk = ~clk;

    router_local_input_buffer #(.FLIT_WIDTH(FW), .BUFFER_DEPTH(DEPTH)) dut (
        .clock       (clk),
        .reset       (reset),
        .rx          (rx),
        .data_i      (data_i),
        .credit_o    (credit_o),
        .req_o       (req_o),
        .dest_o      (dest_o),
        .grant_i     (grant_i),
        .tx          (tx),
        .data_o      (data_o),
        .credit_i    (credit_i),
        .busy_o      (busy_o),
        .occupancy_o (occupancy_o)
`ifdef ROUTER_INBUF_STATS_EN
        ,
        .pkt_count_o (pkt_count_o),
        .drop_count_o(drop_count_o)
`endif
    );

    int compared   = 0;
    int mismatched = 0;

    // Packet-level model: stored flits, phase (0 waiting, 1 requesting, 2 forwarding).
    logic [FW-1:0] mdl_fifo[$];
    int            phase = 0;
    longint        sent = 0;
    longint        total = -1;
    int unsigned   mdl_pkts = 0;
    int unsigned   mdl_drops = 0;
    logic [FW-1:0] last_dest = '0;
    int            req_rises = 0;
    logic          req_prev = 1'b0;
    logic          rand_mode = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    int            pre_size;
    logic [FW-1:0] popped;
    always @(negedge clk) begin
        pre_size = mdl_fifo.size();
        chk("occupancy", 64'(occupancy_o), 64'(pre_size));
        chk("credit", 64'(credit_o), 64'(pre_size != DEPTH));
        chk("req", 64'(req_o), 64'(phase == 1));
        chk("busy", 64'(busy_o), 64'(phase == 2));
        chk("tx", 64'(tx), 64'(phase == 2 && pre_size != 0));
        if (req_o && pre_size != 0) chk("dest", 64'(dest_o), 64'(mdl_fifo[0]));
        if (tx && pre_size != 0) chk("data", 64'(data_o), 64'(mdl_fifo[0]));
`ifdef ROUTER_INBUF_STATS_EN
        chk("pkt_count", 64'(pkt_count_o), 64'(mdl_pkts));
        chk("drop_count", 64'(drop_count_o), 64'(mdl_drops));
`endif
        if (req_o && !req_prev) req_rises++;
        req_prev = req_o;
        if (reset) begin
            mdl_fifo.delete();
            phase = 0; sent = 0; total = -1;
            mdl_pkts = 0; mdl_drops = 0;
            req_prev = 1'b0;
        end else begin
            if (req_o && grant_i) last_dest = dest_o;
            if (phase == 2) begin
                if (tx && credit_i && pre_size != 0) begin
                    popped = mdl_fifo.pop_front();
                    sent++;
                    if (sent == 2) total = 2 + longint'(popped);
                    if (sent >= 2 && sent == total) begin
                        phase = 0;
                        mdl_pkts++;
                    end
                end
            end else if (phase == 1) begin
                if (grant_i) begin
                    phase = 2; sent = 0; total = -1;
                end
            end else if (pre_size != 0) begin
                phase = 1;
            end
            if (rx) begin
                if (pre_size != DEPTH) mdl_fifo.push_back(data_i);
                else mdl_drops++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_mode) begin
            credit_i = ($urandom_range(0, 3) != 0);
            grant_i  = $urandom_range(0, 1) != 0;
        end
    endtask

    task automatic push_flit(input logic [FW-1:0] f);
        logic acc;
        int   guard;
        guard = 0;
        rx = 1'b1;
        data_i = f;
        do begin
            @(negedge clk);
            acc = credit_o;
            tick();
            guard++;
        end while (!acc && guard < 500);
        if (!acc) begin
            mismatched++;
            $display("FAIL push_timeout t=%0t actual=no_credit required=accept", $time);
        end
        rx = 1'b0;
    endtask

    task automatic raw_rx(input logic [FW-1:0] f);
        rx = 1'b1;
        data_i = f;
        tick();
        rx = 1'b0;
    endtask

    task automatic wait_drain();
        int guard;
        guard = 0;
        while ((mdl_fifo.size() != 0 || phase != 0) && guard < 3000) begin
            tick();
            guard++;
        end
        if (guard >= 3000) begin
            mismatched++;
            $display("FAIL drain_timeout t=%0t actual=pending required=idle", $time);
        end
        tick();
    endtask

    initial begin
        int r0;
        int sz;
        repeat (3) tick();
        reset = 1'b0;
        grant_i = 1'b1;
        credit_i = 1'b1;

        // basic packet
        push_flit(32'h11); push_flit(32'h2); push_flit(32'hA); push_flit(32'hB);
        wait_drain();
        chk("t1_dest", 64'(last_dest), 64'h11);

        // zero-size packet
        push_flit(32'h5); push_flit(32'h0);
        wait_drain();
        chk("t2_dest", 64'(last_dest), 64'h5);

        // fill to full with downstream stalled, then one discarded flit
        credit_i = 1'b0;
        push_flit(32'h33); push_flit(32'd14);
        for (int i = 0; i < 14; i++) push_flit(32'h100 + 32'(i));
        @(negedge clk);
        chk("t3_full_occ", 64'(occupancy_o), 64'd16);
        chk("t3_full_credit", 64'(credit_o), 64'd0);
        tick();
        raw_rx(32'hDEAD);
        credit_i = 1'b1;
        wait_drain();

        // upstream gap mid-payload
        push_flit(32'h3); push_flit(32'h4); push_flit(32'hC0); push_flit(32'hC1);
        repeat (6) tick();
        push_flit(32'hC2); push_flit(32'hC3);
        wait_drain();

        // reset pulsed mid-packet
        push_flit(32'h44); push_flit(32'h5); push_flit(32'hA0);
        repeat (6) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("t5_occ", 64'(occupancy_o), 64'd0);
        chk("t5_tx", 64'(tx), 64'd0);
        chk("t5_busy", 64'(busy_o), 64'd0);
        tick();
        push_flit(32'h55); push_flit(32'h1); push_flit(32'hB0);
        wait_drain();
        chk("t5_dest", 64'(last_dest), 64'h55);

        // two packets queued back-to-back
        r0 = req_rises;
        credit_i = 1'b0;
        push_flit(32'h66); push_flit(32'h1); push_flit(32'hD0);
        push_flit(32'h77); push_flit(32'h0);
        credit_i = 1'b1;
        wait_drain();
        chk("t6_req_count", 64'(req_rises - r0), 64'd2);
        chk("t6_dest", 64'(last_dest), 64'h77);

        // randomised traffic with random back-pressure and grants
        rand_mode = 1'b1;
        for (int p = 0; p < 40; p++) begin
            sz = $urandom_range(0, 6);
            push_flit($urandom());
            push_flit(32'(sz));
            for (int k = 0; k < sz; k++) begin
                push_flit($urandom());
                if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) tick();
            end
        end
        rand_mode = 1'b0;
        credit_i = 1'b1;
        grant_i = 1'b1;
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout t=%0t actual=running required=finished", $time);
        $fatal(1, "timeout");
    end
endmodule
